stack_access_unit: RTL and testbench
====================================

STACK_ACCESS_UNIT -- requirements
Module: stack_access_unit

Interface
REQ-001 SHALL have parameter STACK_BASE, default 32'h00001000: exclusive top of stack; highest legal ESP value.
REQ-002 SHALL have parameter STACK_LIMIT, default 32'h00000100: lowest legal push address.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum wait in MEM state, counted in clock cycles.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clock in 1, rising-edge clock; reset in 1, asynchronous active-low reset.
REQ-005 SHALL have these command ports:
- cmd_valid in 1: command request.
- cmd_ready out 1: unit is idle and accepts a command.
- cmd_op in 2: 01 PUSH, 10 POP, 00/11 illegal.
- cmd_data in 32: push data.
REQ-006 SHALL have these ESP ports:
- esp_in in 32: current ESP from the ESP register.
- esp_we out 1: one-cycle ESP write strobe.
- esp_out out 32: new ESP value.
REQ-007 SHALL have these memory ports:
- mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32: request and its address/data.
- mem_ack in 1, mem_rdata in 32: acknowledge and read data.
REQ-008 SHALL have these response ports: rsp_valid out 1; rsp_data out 32 (popped word); err out 1 (one-cycle error pulse).

Function
REQ-009 SHALL implement FSM states IDLE, CHECK, MEM, WB, FAIL; cmd_ready=1 only in IDLE.
REQ-010 SHALL, in IDLE, accept a command when cmd_valid&cmd_ready, latch cmd_op, cmd_data and esp_in, and go to CHECK.
REQ-011 SHALL, in CHECK, compute the 33-bit address without wrap:
- PUSH: addr=esp-4.
- POP: addr=esp.
REQ-012 SHALL, in CHECK, go to FAIL on any of:
- esp[1:0]!=0;
- illegal op;
- PUSH with esp<STACK_LIMIT+4 (this covers esp=0);
- POP with esp+4>STACK_BASE.
Otherwise it SHALL go to MEM.
REQ-013 SHALL hold mem_req=1 with mem_addr, mem_we and mem_wdata stable for every cycle in MEM until mem_ack is sampled high.
REQ-014 SHALL drive mem_we=1 and mem_wdata=latched data for PUSH, and mem_we=0 for POP.
REQ-015 SHALL, on mem_ack in MEM, capture mem_rdata (POP only), drop mem_req next cycle, and go to WB.
REQ-016 SHALL ignore mem_ack outside MEM.
REQ-017 SHALL, in WB, pulse esp_we=1 for exactly one cycle with esp_out=esp-4 (PUSH) or esp+4 (POP), pulse rsp_valid=1, present rsp_data (POP: read word; PUSH: 0), then return to IDLE.
REQ-018 SHALL count MEM cycles; if mem_ack has not arrived after TIMEOUT cycles, drop mem_req and go to FAIL; mem_ack arriving in the expiry cycle SHALL take priority over the timeout.
REQ-019 SHALL, in FAIL, pulse err=1 for one cycle with no esp_we, no rsp_valid and no further mem_req, then return to IDLE.
REQ-020 SHALL have an accept-to-mem_req latency of 2 cycles and a mem_ack-to-esp_we latency of 1 cycle; a zero-wait memory (mem_ack in the first MEM cycle) SHALL give 4 cycles per command from accept to IDLE.
REQ-021 SHALL NOT alter an accepted command when cmd_valid or esp_in change after acceptance.

Reset
REQ-022 SHALL, while reset=0, force state=IDLE, cmd_ready=1, mem_req=0, mem_we=0, esp_we=0, rsp_valid=0, err=0, all data/address outputs=0 and the timeout counter=0, asynchronously.
REQ-023 SHALL, when reset asserts mid-operation, abandon the transaction with no esp_we and no err.
REQ-024 SHALL NOT accept a command in the first clock edge after reset release; the first accept occurs on the second edge at earliest.

Structure
REQ-025 SHALL place the op codes (PUSH/POP), the FSM state encoding and the constant WORD_BYTES=4 in shared package stack_pkg.
REQ-026 SHALL use one combinational sub-module, stack_bounds_check (inputs: op, esp; outputs: addr, new_esp, fault), instantiated once.

Verification
REQ-027 SHALL cover PUSH with esp_in=0x1000, cmd_data=0xDEADBEEF, mem_ack after 3 cycles -> mem write to addr 0xFFC with data 0xDEADBEEF; esp_we with esp_out=0xFFC; rsp_valid; err=0.
REQ-028 SHALL cover POP with esp_in=0xFFC, mem_rdata=0x12345678, zero-wait memory -> read at addr 0xFFC; rsp_data=0x12345678; esp_out=0x1000; total 4 cycles.
REQ-029 SHALL cover boundary faults: PUSH with esp_in=0x100, POP with esp_in=0x1000, esp_in=0x0FFE, cmd_op=11 -> each gives err pulse, no mem_req, no esp_we.
REQ-030 SHALL cover timeouts: no mem_ack -> mem_req held 16 cycles then dropped, err pulse, no esp_we; mem_ack in cycle 16 -> normal WB, no err.
REQ-031 SHALL cover reset=0 asserted during MEM of a PUSH -> mem_req=0 immediately, no esp_we, and cmd_ready=1 after release.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: op codes, FSM encoding and word size shared by the stack access unit
package stack_pkg;
    localparam int         WORD_BYTES = 4;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    typedef enum logic [2:0] {IDLE, CHECK, MEM, WB, FAIL} state_t;
endpackage

// File: rtl/stack_access_unit_if.sv
// stack_access_unit_if: command, ESP, memory and response signals of the stack unit
interface stack_access_unit_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [31:0] esp_in;
    logic        esp_we;
    logic [31:0] esp_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        err;
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, esp_in, mem_ack, mem_rdata,
        output cmd_ready, esp_we, esp_out, mem_req, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_data, err
    );
    modport master (
        output cmd_valid, cmd_op, cmd_data, esp_in, mem_ack, mem_rdata,
        input  cmd_ready, esp_we, esp_out, mem_req, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_data, err
    );
endinterface

// File: rtl/stack_bounds_check.sv
// stack_bounds_check: access address, updated ESP and fault flag for a push/pop
module stack_bounds_check
    import stack_pkg::*;
#(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0100
) (
    input  logic [1:0]  op,
    input  logic [31:0] esp,
    output logic [31:0] addr,
    output logic [31:0] new_esp,
    output logic        fault
);
    logic        is_push;
    logic        is_pop;
    logic [32:0] esp_x;
    assign is_push = op == OP_PUSH;
    assign is_pop  = op == OP_POP;
    assign esp_x   = {1'b0, esp};
    assign addr    = is_push ? esp - 32'(WORD_BYTES) : esp;
    assign new_esp = is_push ? esp - 32'(WORD_BYTES) : esp + 32'(WORD_BYTES);
    // comparisons are 33 bits wide so esp near 0 or 2^32 cannot wrap past a bound
    assign fault   = (|esp[1:0]) || !(is_push || is_pop)
                  || (is_push && esp_x < {1'b0, STACK_LIMIT} + 33'(WORD_BYTES))
                  || (is_pop && esp_x + 33'(WORD_BYTES) > {1'b0, STACK_BASE});
endmodule

// File: rtl/stack_access_unit.sv
// stack_access_unit: bounds-checked push/pop of one word with ESP update and memory timeout
module stack_access_unit
    import stack_pkg::*;
#(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0100,
    parameter int          TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    stack_access_unit_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        state, state_nx;
    logic          armed;
    logic          accept;
    logic          expired;
    logic [1:0]    op_r;
    logic [31:0]   data_r, esp_r, rdata_r;
    logic [CW-1:0] cnt;
    logic [31:0]   addr, new_esp;
    logic          fault;

    stack_bounds_check #(
        .STACK_BASE (STACK_BASE),
        .STACK_LIMIT(STACK_LIMIT)
    ) u_bounds (
        .op     (op_r),
        .esp    (esp_r),
        .addr   (addr),
        .new_esp(new_esp),
        .fault  (fault)
    );

    // armed stays low for the first edge after reset so that edge cannot accept
    assign accept  = bus.cmd_valid && state == IDLE && armed;
    assign expired = cnt == CW'(TIMEOUT - 1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // command latch, read-data capture and MEM cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            op_r    <= '0;
            data_r  <= '0;
            esp_r   <= '0;
            rdata_r <= '0;
            cnt     <= '0;
        end else begin
            armed <= 1'b1;
            cnt   <= state == MEM ? cnt + CW'(1) : '0;
            if (accept) begin
                op_r   <= bus.cmd_op;
                data_r <= bus.cmd_data;
                esp_r  <= bus.esp_in;
            end
            if (state == MEM && bus.mem_ack) rdata_r <= op_r == OP_POP ? bus.mem_rdata : '0;
        end
    end

    // next-state and output decode
    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.esp_we    = 1'b0;
        bus.esp_out   = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.err       = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (accept) state_nx = CHECK;
            end
            CHECK: state_nx = fault ? FAIL : MEM;
            MEM: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = op_r == OP_PUSH;
                bus.mem_addr  = addr;
                bus.mem_wdata = op_r == OP_PUSH ? data_r : '0;
                if (bus.mem_ack) state_nx = WB;
                else if (expired) state_nx = FAIL;
            end
            WB: begin
                bus.esp_we    = 1'b1;
                bus.esp_out   = new_esp;
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = rdata_r;
                state_nx      = IDLE;
            end
            FAIL: begin
                bus.err  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_stack_access_unit.sv
// tb_stack_access_unit: directed push/pop, fault, timeout and reset vectors
module tb_stack_access_unit;
    import stack_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int n, req_cnt, we_cnt, rsp_cnt, err_cnt, ack_n, we_n, req_n, unstable;
    logic [31:0] addr_v, wdata_v, esp_v, rsp_v;
    logic we_v;

    stack_access_unit_if bus();
    stack_access_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // present a command for one edge, then scramble the inputs
    task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [31:0] esp);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.esp_in    = esp;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b11;
        bus.cmd_data  = 32'hFFFF_FFFF;
        bus.esp_in    = 32'hFFFF_FFF3;
    endtask

    // memory responder and monitor until back in IDLE; ack_at=0 never acks
    task automatic run(input int ack_at);
        int mcyc = 0;
        n = 1; req_cnt = 0; we_cnt = 0; rsp_cnt = 0; err_cnt = 0;
        ack_n = 0; we_n = 0; req_n = 0; unstable = 0;
        addr_v = '0; wdata_v = '0; esp_v = '0; rsp_v = '0; we_v = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_req) begin
                mcyc++;
                req_cnt++;
                if (mcyc == 1) begin
                    addr_v = bus.mem_addr; wdata_v = bus.mem_wdata; we_v = bus.mem_we; req_n = n;
                end else if (bus.mem_addr !== addr_v || bus.mem_wdata !== wdata_v || bus.mem_we !== we_v)
                    unstable++;
                bus.mem_ack = mcyc == ack_at;
                if (bus.mem_ack) ack_n = n;
            end else bus.mem_ack = 1'b0;
            if (bus.esp_we) begin we_cnt++; we_n = n; esp_v = bus.esp_out; end
            if (bus.rsp_valid) begin rsp_cnt++; rsp_v = bus.rsp_data; end
            if (bus.err) err_cnt++;
            if (bus.cmd_ready) return;
        end
        chk("back_to_idle", bus.cmd_ready, 1);
    endtask

    task automatic cmd_ok(input string t, input logic [1:0] op, input logic [31:0] data,
                          input logic [31:0] esp, input int ack_at, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [31:0] e_esp,
                          input logic [31:0] e_rsp, input int e_n);
        bus.mem_rdata = rdata;
        issue(op, data, esp);
        chk({t, "_accept"}, bus.cmd_ready, 0);
        run(ack_at);
        chk({t, "_addr"}, addr_v, e_addr);
        chk({t, "_mem_we"}, we_v, op == OP_PUSH);
        if (op == OP_PUSH) chk({t, "_wdata"}, wdata_v, data);
        chk({t, "_req_cycles"}, req_cnt, ack_at);
        chk({t, "_req_stable"}, unstable, 0);
        chk({t, "_req_latency"}, req_n, 2);
        chk({t, "_esp_we_cnt"}, we_cnt, 1);
        chk({t, "_ack_to_we"}, we_n - ack_n, 1);
        chk({t, "_esp_out"}, esp_v, e_esp);
        chk({t, "_rsp_cnt"}, rsp_cnt, 1);
        chk({t, "_rsp_data"}, rsp_v, e_rsp);
        chk({t, "_err_cnt"}, err_cnt, 0);
        chk({t, "_cycles"}, n, e_n);
    endtask

    task automatic cmd_bad(input string t, input logic [1:0] op, input logic [31:0] esp);
        issue(op, 32'h5A5A_5A5A, esp);
        run(1);
        chk({t, "_err_cnt"}, err_cnt, 1);
        chk({t, "_req_cnt"}, req_cnt, 0);
        chk({t, "_esp_we_cnt"}, we_cnt, 0);
        chk({t, "_rsp_cnt"}, rsp_cnt, 0);
        chk({t, "_cycles"}, n, 3);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0; bus.esp_in = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        #2;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_esp_we", bus.esp_we, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_esp_out", bus.esp_out, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        cmd_ok("push", OP_PUSH, 32'hDEAD_BEEF, 32'h0000_1000, 3, 32'h5555_5555,
               32'h0000_0FFC, 32'h0000_0FFC, 32'h0, 6);
        cmd_ok("pop", OP_POP, 32'h0, 32'h0000_0FFC, 1, 32'h1234_5678,
               32'h0000_0FFC, 32'h0000_1000, 32'h1234_5678, 4);
        cmd_ok("push_lim", OP_PUSH, 32'h0BAD_F00D, 32'h0000_0104, 2, 32'h7777_7777,
               32'h0000_0100, 32'h0000_0100, 32'h0, 5);
        cmd_ok("pop_lim", OP_POP, 32'h0, 32'h0000_0100, 1, 32'h0BAD_F00D,
               32'h0000_0100, 32'h0000_0104, 32'h0BAD_F00D, 4);
        cmd_ok("ack16", OP_PUSH, 32'hCAFE_F00D, 32'h0000_0800, 16, 32'h0,
               32'h0000_07FC, 32'h0000_07FC, 32'h0, 19);

        cmd_bad("push_under", OP_PUSH, 32'h0000_0100);
        cmd_bad("push_zero", OP_PUSH, 32'h0000_0000);
        cmd_bad("pop_over", OP_POP, 32'h0000_1000);
        cmd_bad("misalign", OP_PUSH, 32'h0000_0FFE);
        cmd_bad("op11", 2'b11, 32'h0000_0800);

        issue(OP_PUSH, 32'hA5A5_A5A5, 32'h0000_0800);
        run(0);
        chk("to_req_cycles", req_cnt, 16);
        chk("to_req_stable", unstable, 0);
        chk("to_err_cnt", err_cnt, 1);
        chk("to_esp_we_cnt", we_cnt, 0);
        chk("to_rsp_cnt", rsp_cnt, 0);
        chk("to_cycles", n, 19);

        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("stray_ack_ready", bus.cmd_ready, 1);
        chk("stray_ack_we", bus.esp_we, 0);
        @(posedge clk); #1;
        chk("stray_ack_rsp", bus.rsp_valid, 0);
        bus.mem_ack = 1'b0;

        issue(OP_PUSH, 32'h1111_2222, 32'h0000_1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rmid_in_mem", bus.mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_mem_req", bus.mem_req, 0);
        chk("rmid_cmd_ready", bus.cmd_ready, 1);
        chk("rmid_esp_we", bus.esp_we, 0);
        chk("rmid_err", bus.err, 0);
        chk("rmid_mem_addr", bus.mem_addr, 0);
        bus.mem_rdata = 32'h3C3C_C3C3;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_POP; bus.cmd_data = '0; bus.esp_in = 32'h0000_0FFC;
        @(posedge clk); #1;
        chk("rhold_esp_we", bus.esp_we, 0);
        chk("rhold_err", bus.err, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rrel_first_edge_idle", bus.cmd_ready, 1);
        chk("rrel_first_edge_err", bus.err, 0);
        @(posedge clk); #1;
        chk("rrel_second_edge_acc", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0; bus.esp_in = 32'hFFFF_FFF3;
        run(1);
        chk("rrel_esp_we_cnt", we_cnt, 1);
        chk("rrel_esp_out", esp_v, 32'h0000_1000);
        chk("rrel_rsp_data", rsp_v, 32'h3C3C_C3C3);
        chk("rrel_err_cnt", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
